fetch_sequencer: RTL and testbench

Controls the instruction-fetch PC register. Each cycle it generates the PC write enable and the next PC value: sequential increment, branch or jump target. It also generates the IF/ID enable and flush, holds fetch during load-use stalls, and parks the pipeline on halt or stall watchdog expiry. It sits between the hazard/branch logic and the PC register plus the IF/ID pipeline register.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register load and IF/ID enable/flush from
// branch, jump, stall and halt requests, with a stall watchdog and fetch counter.
module fetch_sequencer #(
    parameter logic [9:0]  RESET_VECTOR = 10'd0,
    parameter logic [9:0]  PC_STEP      = 10'd1,
    parameter int unsigned FLUSH_DEPTH  = 2,
    parameter logic [7:0]  MAX_STALL    = 8'd64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  pc_current,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic        jump,
    input  logic [9:0]  jump_target,
    input  logic        halt,
    output logic        pc_write,
    output logic [9:0]  pc_new,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        fetch_valid,
    output logic        halted,
    output logic        stall_timeout,
    output logic [15:0] fetch_count
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_DEPTH > 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        stall_timeout_q, stall_timeout_d;

    logic [9:0]  pc_seq;
    logic        redirect;
    logic [9:0]  redirect_pc;

    assign pc_seq      = pc_current + PC_STEP;
    assign redirect    = branch_taken | jump;
    // The branch in EX is older than the jump in ID, so its target wins.
    assign redirect_pc = branch_taken ? branch_target : jump_target;

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        stall_cnt_d     = '0;
        stall_timeout_d = stall_timeout_q;
        fetch_count_d   = fetch_count_q;
        pc_write        = 1'b0;
        pc_new          = pc_seq;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        fetch_valid     = 1'b0;
        halted          = 1'b0;

        if ((state_q == RUN || state_q == FLUSH) && redirect) begin
            pc_write    = 1'b1;
            pc_new      = redirect_pc;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = MULTI_FLUSH ? FLUSH : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    if_id_flush = 1'b1;
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (stall_req) begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                        if (stall_cnt_d == MAX_STALL) begin
                            stall_timeout_d = 1'b1;
                            state_d         = HALT;
                        end
                    end else if (halt) begin
                        if_id_flush = 1'b1;
                        state_d     = HALT;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        fetch_valid = 1'b1;
                    end
                end
                FLUSH: begin
                    // Stall and halt here come from squashed instructions.
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                HALT: begin
                    halted      = 1'b1;
                    if_id_flush = 1'b1;
                    if (start) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end

        if ((state_q == RUN || state_q == FLUSH) && pc_write && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        if (reset) begin
            pc_write    = 1'b1;
            pc_new      = RESET_VECTOR;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            fetch_valid = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            flush_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            fetch_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            fetch_count_q   <= fetch_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the sequencer.
module tb_fetch_sequencer;

    localparam logic [9:0] RV   = 10'd0;
    localparam logic [9:0] STEP = 10'd1;
    localparam int         FD   = 2;
    localparam logic [7:0] MS   = 8'd4;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_FLUSH = 2;
    localparam int MD_PARK  = 3;

    logic        clock = 1'b0;
    logic        reset, start, stall_req, branch_taken, jump, halt;
    logic [9:0]  pc_current = 10'd0;
    logic [9:0]  branch_target, jump_target, pc_new;
    logic        pc_write, if_id_write, if_id_flush, fetch_valid, halted, stall_timeout;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state and per-cycle expectations
    int         m_mode = MD_IDLE, m_flush_left = 0, m_stall_run = 0, m_count = 0;
    bit         m_timeout = 1'b0;
    logic [9:0] m_pc = 10'd0;
    int         n_mode, n_flush_left, n_stall_run, n_count;
    bit         n_timeout;
    logic [9:0] n_pc;
    bit         e_pw, e_ifw, e_ifw_chk, e_fl, e_fl_chk, e_fv, e_halted;
    logic [9:0] e_pn;

    fetch_sequencer #(
        .RESET_VECTOR(RV), .PC_STEP(STEP), .FLUSH_DEPTH(FD), .MAX_STALL(MS)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pc_current(pc_current),
        .stall_req(stall_req), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt),
        .pc_write(pc_write), .pc_new(pc_new), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .fetch_valid(fetch_valid), .halted(halted),
        .stall_timeout(stall_timeout), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // The PC register that the sequencer controls
    always @(posedge clock) if (pc_write) pc_current <= pc_new;

    task automatic model_eval();
        bit         redir;
        logic [9:0] tgt;
        e_pw = 0; e_ifw = 0; e_ifw_chk = 1; e_fl = 0; e_fl_chk = 1; e_fv = 0; e_halted = 0;
        e_pn = 10'((int'(m_pc) + int'(STEP)) % 1024);
        n_mode = m_mode; n_flush_left = m_flush_left; n_stall_run = 0;
        n_timeout = m_timeout; n_count = m_count; n_pc = m_pc;
        redir = branch_taken || jump;
        tgt   = branch_taken ? branch_target : jump_target;
        if (reset) begin
            e_pw = 1; e_pn = RV; e_fl = 1;
            n_mode = MD_IDLE; n_flush_left = 0; n_timeout = 0; n_count = 0;
        end else begin
            case (m_mode)
                MD_IDLE: begin
                    e_fl = 1;
                    if (start) n_mode = MD_RUN;
                end
                MD_RUN, MD_FLUSH: begin
                    if (redir) begin
                        e_pw = 1; e_pn = tgt; e_fl = 1; e_ifw_chk = 0;
                        n_flush_left = FD - 1;
                        n_mode = (FD > 1) ? MD_FLUSH : MD_RUN;
                    end else if (m_mode == MD_FLUSH) begin
                        e_pw = 1; e_ifw = 1; e_fl = 1;
                        n_flush_left = m_flush_left - 1;
                        if (n_flush_left == 0) n_mode = MD_RUN;
                    end else if (stall_req) begin
                        n_stall_run = m_stall_run + 1;
                        if (n_stall_run >= int'(MS)) begin
                            n_timeout = 1; n_mode = MD_PARK;
                        end
                    end else if (halt) begin
                        e_fl = 1; e_ifw_chk = 0; n_mode = MD_PARK;
                    end else begin
                        e_pw = 1; e_ifw = 1; e_fv = 1;
                    end
                end
                default: begin
                    e_halted = 1; e_fl_chk = 0;
                    if (start) n_mode = MD_RUN;
                end
            endcase
        end
        if (e_pw) begin
            n_pc = e_pn;
            if (!reset && m_count < 65535) n_count = m_count + 1;
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit stl, input bit br,
                         input logic [9:0] bt, input bit jp, input logic [9:0] jt, input bit hl);
        reset = rst; start = st; stall_req = stl; branch_taken = br;
        branch_target = bt; jump = jp; jump_target = jt; halt = hl;
        #1;
        model_eval();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 10'd0, 0, 10'd0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        m_mode = n_mode; m_flush_left = n_flush_left; m_stall_run = n_stall_run;
        m_count = n_count; m_timeout = n_timeout; m_pc = n_pc;
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 10'd0, 0, 10'd0, 0);
        n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pc_write: got %b want 1", pc_write); end
        n_checks++; if (pc_new !== RV) begin n_fail++; $display("[TB] FAIL reset_pc_new: got %0d want %0d", pc_new, RV); end
        n_checks++; if (if_id_flush !== 1'b1 || if_id_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_id: got flush=%b write=%b want 1/0", if_id_flush, if_id_write); end
        n_checks++; if (fetch_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_halted: got %b/%b want 0/0", fetch_valid, halted); end
        tick();
        drive(1, 0, 0, 0, 10'd0, 0, 10'd0, 0);
        tick();
        idle();
        n_checks++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_outputs: got pw=%b fl=%b fv=%b want 0/1/0", pc_write, if_id_flush, fetch_valid); end
        n_checks++; if (fetch_count !== 16'd0 || stall_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regs: got cnt=%0d to=%b want 0/0", fetch_count, stall_timeout); end
        n_checks++; if (pc_current !== RV) begin n_fail++; $display("[TB] FAIL reset_pc: got %0d want %0d", pc_current, RV); end
    endtask

    task automatic test_sequential();
        drive(0, 1, 0, 0, 10'd0, 0, 10'd0, 0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            idle();
            n_checks++; if (fetch_valid !== 1'b1 || pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid: got fv=%b pw=%b want 1/1", fetch_valid, pc_write); end
            tick();
            n_checks++; if (pc_current !== 10'(i)) begin n_fail++; $display("[TB] FAIL seq_pc: got %0d want %0d", pc_current, i); end
        end
        n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("[TB] FAIL seq_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_branch_flush();
        idle(); tick();
        idle(); tick();
        n_checks++; if (pc_current !== 10'd5) begin n_fail++; $display("[TB] FAIL br_setup_pc: got %0d want 5", pc_current); end
        drive(0, 0, 0, 1, 10'd40, 0, 10'd0, 0);
        n_checks++; if (pc_new !== 10'd40 || if_id_flush !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_redirect: got pn=%0d fl=%b fv=%b want 40/1/0", pc_new, if_id_flush, fetch_valid); end
        tick();
        n_checks++; if (pc_current !== 10'd40) begin n_fail++; $display("[TB] FAIL br_pc: got %0d want 40", pc_current); end
        idle();
        n_checks++; if (pc_new !== 10'd41 || if_id_flush !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_flush2: got pn=%0d fl=%b fv=%b want 41/1/0", pc_new, if_id_flush, fetch_valid); end
        tick();
        idle();
        n_checks++; if (pc_new !== 10'd42 || if_id_flush !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL br_resume: got pn=%0d fl=%b fv=%b want 42/0/1", pc_new, if_id_flush, fetch_valid); end
        tick();
    endtask

    task automatic test_priority();
        drive(0, 0, 1, 1, 10'd40, 1, 10'd90, 1);
        n_checks++; if (pc_new !== 10'd40 || pc_write !== 1'b1 || if_id_flush !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_branch: got pn=%0d pw=%b fl=%b want 40/1/1", pc_new, pc_write, if_id_flush); end
        tick();
        drive(0, 0, 0, 0, 10'd0, 1, 10'd90, 0);
        n_checks++; if (pc_new !== 10'd90 || pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_rejump: got pn=%0d pw=%b want 90/1", pc_new, pc_write); end
        tick();
        drive(0, 0, 1, 0, 10'd0, 0, 10'd0, 1);
        n_checks++; if (pc_new !== 10'd91 || pc_write !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ignore: got pn=%0d pw=%b h=%b want 91/1/0", pc_new, pc_write, halted); end
        tick();
    endtask

    task automatic test_stall_watchdog();
        drive(0, 0, 0, 0, 10'd0, 1, 10'd6, 0); tick();
        idle(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 10'd0, 0, 10'd0, 0);
            n_checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_hold: got pw=%b ifw=%b want 0/0", pc_write, if_id_write); end
            tick();
            n_checks++; if (pc_current !== 10'd7) begin n_fail++; $display("[TB] FAIL stall_pc: got %0d want 7", pc_current); end
        end
        idle();
        n_checks++; if (pc_new !== 10'd8 || stall_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release: got pn=%0d to=%b want 8/0", pc_new, stall_timeout); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 10'd0, 0, 10'd0, 0); tick();
        end
        idle();
        n_checks++; if (stall_timeout !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("[TB] FAIL watchdog: got to=%b h=%b want 1/1", stall_timeout, halted); end
        drive(0, 1, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        idle();
        n_checks++; if (stall_timeout !== 1'b1 || halted !== 1'b0 || pc_new !== 10'd9) begin n_fail++; $display("[TB] FAIL watchdog_resume: got to=%b h=%b pn=%0d want 1/0/9", stall_timeout, halted, pc_new); end
    endtask

    task automatic test_wrap_halt();
        drive(0, 0, 0, 0, 10'd0, 1, 10'd1022, 0); tick();
        idle(); tick();
        idle();
        n_checks++; if (pc_current !== 10'd1023 || pc_new !== 10'd0) begin n_fail++; $display("[TB] FAIL wrap: got pc=%0d pn=%0d want 1023/0", pc_current, pc_new); end
        tick();
        drive(0, 0, 0, 0, 10'd0, 0, 10'd0, 1);
        n_checks++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_cycle: got pw=%b fl=%b want 0/1", pc_write, if_id_flush); end
        tick();
        idle();
        n_checks++; if (halted !== 1'b1 || pc_write !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halted: got h=%b pw=%b fv=%b want 1/0/0", halted, pc_write, fetch_valid); end
        tick();
        n_checks++; if (pc_current !== 10'd0) begin n_fail++; $display("[TB] FAIL halt_frozen: got %0d want 0", pc_current); end
        drive(0, 1, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        idle();
        n_checks++; if (pc_new !== 10'd1 || fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_resume: got pn=%0d fv=%b want 1/1", pc_new, fetch_valid); end
        tick();
    endtask

    task automatic test_reset_in_flush();
        drive(1, 0, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        drive(0, 1, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        drive(0, 0, 0, 1, 10'd300, 0, 10'd0, 0); tick();
        drive(1, 0, 0, 0, 10'd0, 0, 10'd0, 0);
        n_checks++; if (pc_new !== RV || pc_write !== 1'b1) begin n_fail++; $display("[TB] FAIL rstflush_pc_new: got pn=%0d pw=%b want %0d/1", pc_new, pc_write, RV); end
        tick();
        idle();
        n_checks++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || fetch_count !== 16'd0 || pc_current !== RV) begin n_fail++; $display("[TB] FAIL rstflush_idle: got pw=%b fl=%b cnt=%0d pc=%0d want 0/1/0/%0d", pc_write, if_id_flush, fetch_count, pc_current, RV); end
    endtask

    task automatic test_random();
        drive(1, 0, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        drive(0, 1, 0, 0, 10'd0, 0, 10'd0, 0); tick();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 10'($urandom), ($urandom_range(0, 7) == 0), 10'($urandom),
                  ($urandom_range(0, 31) == 0));
            n_checks++; if (pc_current !== m_pc) begin n_fail++; $display("[TB] FAIL rnd_pc cyc %0d: got %0d want %0d", i, pc_current, m_pc); end
            n_checks++; if (pc_write !== e_pw || (e_pw && pc_new !== e_pn)) begin n_fail++; $display("[TB] FAIL rnd_pc_write cyc %0d: got pw=%b pn=%0d want %b/%0d", i, pc_write, pc_new, e_pw, e_pn); end
            n_checks++; if ((e_ifw_chk && if_id_write !== e_ifw) || (e_fl_chk && if_id_flush !== e_fl)) begin n_fail++; $display("[TB] FAIL rnd_if_id cyc %0d: got w=%b f=%b want %b/%b", i, if_id_write, if_id_flush, e_ifw, e_fl); end
            n_checks++; if (fetch_valid !== e_fv || halted !== e_halted) begin n_fail++; $display("[TB] FAIL rnd_valid_halted cyc %0d: got %b/%b want %b/%b", i, fetch_valid, halted, e_fv, e_halted); end
            n_checks++; if (stall_timeout !== m_timeout || fetch_count !== 16'(m_count)) begin n_fail++; $display("[TB] FAIL rnd_regs cyc %0d: got to=%b cnt=%0d want %b/%0d", i, stall_timeout, fetch_count, m_timeout, m_count); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_flush();
        test_priority();
        test_stall_watchdog();
        test_wrap_halt();
        test_reset_in_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
